// File: rtl/axi4_stream_pkg.sv
// rtl/axi4_stream_pkg.sv - shared types and helpers for the AXI4-Stream packet blocks
// Contents: FSM state type, byte-count width helpers, popcount over a keep/strb mask.
package axi4_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MERGE = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   // Widest keep/strb mask popcount() accepts; callers zero-extend into it.
   localparam int unsigned POPCNT_MAX_BITS = 128;

   // Bytes per beat for a given tdata width.
   function automatic int unsigned data_width_b(input int unsigned data_width);
      return data_width / 8;
   endfunction

   // Width of a byte counter that must hold 0..2W-1 (residue plus one beat).
   function automatic int unsigned byte_cnt_width(input int unsigned w);
      return $clog2(w) + 1;
   endfunction

   function automatic int unsigned popcount(input logic [POPCNT_MAX_BITS-1:0] vec);
      int unsigned n;
      n = 0;
      for (int i = 0; i < POPCNT_MAX_BITS; i++) begin
         n = n + 32'(vec[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/axi4_stream_byte_packer.sv
// rtl/axi4_stream_byte_packer.sv - combinational residue + beat byte packer
// Ports: res_*_i   residue bytes (r_i valid, LSB-aligned)
//        in_*_i    incoming beat (v_i valid bytes, LSB-aligned)
//        packed_*_o 2W-byte word {in << 8r | residue} with matching masks
//        s_o       total valid bytes r_i + v_i
module axi4_stream_byte_packer
   import axi4_stream_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int DATA_WIDTH_B = 4,
   parameter int BCNT_WIDTH   = 3
) (
   input  logic [DATA_WIDTH-1:0]     res_data_i,
   input  logic [DATA_WIDTH_B-1:0]   res_keep_i,
   input  logic [DATA_WIDTH_B-1:0]   res_strb_i,
   input  logic [BCNT_WIDTH-1:0]     r_i,
   input  logic [DATA_WIDTH-1:0]     in_data_i,
   input  logic [DATA_WIDTH_B-1:0]   in_keep_i,
   input  logic [DATA_WIDTH_B-1:0]   in_strb_i,
   input  logic [BCNT_WIDTH-1:0]     v_i,
   output logic [2*DATA_WIDTH-1:0]   packed_data_o,
   output logic [2*DATA_WIDTH_B-1:0] packed_keep_o,
   output logic [2*DATA_WIDTH_B-1:0] packed_strb_o,
   output logic [BCNT_WIDTH-1:0]     s_o
);

   logic [DATA_WIDTH_B-1:0] in_mask;
   logic [DATA_WIDTH-1:0]   in_data_m;

   always_comb begin
      in_mask   = '0;
      in_data_m = '0;
      // Bytes beyond the valid count are zeroed so they never leak into the
      // residue or into the don't-care lanes of a partial output beat.
      for (int i = 0; i < DATA_WIDTH_B; i++) begin
         in_mask[i] = (i < int'(v_i));
         in_data_m[8*i +: 8] = in_mask[i] ? in_data_i[8*i +: 8] : 8'h00;
      end
      packed_data_o = ({{DATA_WIDTH{1'b0}}, in_data_m} << {r_i, 3'b000})
                    | {{DATA_WIDTH{1'b0}}, res_data_i};
      packed_keep_o = ({{DATA_WIDTH_B{1'b0}}, in_keep_i & in_mask} << r_i)
                    | {{DATA_WIDTH_B{1'b0}}, res_keep_i};
      packed_strb_o = ({{DATA_WIDTH_B{1'b0}}, in_strb_i & in_mask} << r_i)
                    | {{DATA_WIDTH_B{1'b0}}, res_strb_i};
      s_o = r_i + v_i;
   end

endmodule

// File: rtl/axi4_stream_pkt_merge.sv
// rtl/axi4_stream_pkt_merge.sv - merges merge_cnt_i stream fragments into one dense packet
// Ports: clk_i, rst_i (async, active-high); merge_cnt_i fragments per packet (0 -> 1)
//        pkt_in_*  fragment input stream (slave), pkt_in_tready_o back-pressure
//        pkt_out_* merged output stream (master), registered
module axi4_stream_pkt_merge
   import axi4_stream_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ID_WIDTH      = 1,
   parameter int DEST_WIDTH    = 1,
   parameter int USER_WIDTH    = 1,
   parameter int MAX_MERGE_CNT = 16,
   parameter int CNT_WIDTH     = $clog2(MAX_MERGE_CNT) + 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [CNT_WIDTH-1:0]    merge_cnt_i,
   input  logic [DATA_WIDTH-1:0]   pkt_in_tdata_i,
   input  logic [DATA_WIDTH/8-1:0] pkt_in_tkeep_i,
   input  logic [DATA_WIDTH/8-1:0] pkt_in_tstrb_i,
   input  logic                    pkt_in_tlast_i,
   input  logic [ID_WIDTH-1:0]     pkt_in_tid_i,
   input  logic [DEST_WIDTH-1:0]   pkt_in_tdest_i,
   input  logic [USER_WIDTH-1:0]   pkt_in_tuser_i,
   input  logic                    pkt_in_tvalid_i,
   output logic                    pkt_in_tready_o,
   output logic [DATA_WIDTH-1:0]   pkt_out_tdata_o,
   output logic [DATA_WIDTH/8-1:0] pkt_out_tkeep_o,
   output logic [DATA_WIDTH/8-1:0] pkt_out_tstrb_o,
   output logic                    pkt_out_tlast_o,
   output logic [ID_WIDTH-1:0]     pkt_out_tid_o,
   output logic [DEST_WIDTH-1:0]   pkt_out_tdest_o,
   output logic [USER_WIDTH-1:0]   pkt_out_tuser_o,
   output logic                    pkt_out_tvalid_o,
   input  logic                    pkt_out_tready_i
);

   localparam int W  = int'(data_width_b(DATA_WIDTH));
   localparam int BW = int'(byte_cnt_width(W));

   state_e                state_q;
   logic [BW-1:0]         r_q;
   logic [DATA_WIDTH-1:0] res_data_q;
   logic [W-1:0]          res_keep_q;
   logic [W-1:0]          res_strb_q;
   logic [CNT_WIDTH-1:0]  frag_cnt_q;
   logic [CNT_WIDTH-1:0]  merge_cnt_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [DEST_WIDTH-1:0] dest_q;
   logic [USER_WIDTH-1:0] user_q;

   logic [DATA_WIDTH-1:0] out_data_q;
   logic [W-1:0]          out_keep_q;
   logic [W-1:0]          out_strb_q;
   logic                  out_last_q;
   logic                  out_valid_q;
   logic [ID_WIDTH-1:0]   out_id_q;
   logic [DEST_WIDTH-1:0] out_dest_q;
   logic [USER_WIDTH-1:0] out_user_q;

   logic [BW-1:0]           v;
   logic [BW-1:0]           s;
   logic [2*DATA_WIDTH-1:0] packed_data;
   logic [2*W-1:0]          packed_keep;
   logic [2*W-1:0]          packed_strb;
   logic [CNT_WIDTH-1:0]    cnt_live;
   logic [CNT_WIDTH-1:0]    cnt_target;
   logic [CNT_WIDTH-1:0]    frag_next;
   logic                    first_beat;
   logic                    merge_end;
   logic                    s_ge_w;
   logic                    s_gt_w;
   logic                    emit;
   logic                    out_load;

   assign v = BW'(popcount(POPCNT_MAX_BITS'(pkt_in_tkeep_i | pkt_in_tstrb_i)));

   axi4_stream_byte_packer #(
      .DATA_WIDTH  (DATA_WIDTH),
      .DATA_WIDTH_B(W),
      .BCNT_WIDTH  (BW)
   ) u_packer (
      .res_data_i   (res_data_q),
      .res_keep_i   (res_keep_q),
      .res_strb_i   (res_strb_q),
      .r_i          (r_q),
      .in_data_i    (pkt_in_tdata_i),
      .in_keep_i    (pkt_in_tkeep_i),
      .in_strb_i    (pkt_in_tstrb_i),
      .v_i          (v),
      .packed_data_o(packed_data),
      .packed_keep_o(packed_keep),
      .packed_strb_o(packed_strb),
      .s_o          (s)
   );

   // Zero means one fragment; anything above the supported maximum is clamped.
   assign cnt_live   = (merge_cnt_i == '0) ? CNT_WIDTH'(1) :
                       (merge_cnt_i > CNT_WIDTH'(MAX_MERGE_CNT)) ? CNT_WIDTH'(MAX_MERGE_CNT) :
                       merge_cnt_i;
   // The first beat of a merge has not latched the count yet, so use the live value.
   assign first_beat = (state_q == ST_IDLE);
   assign cnt_target = first_beat ? cnt_live : merge_cnt_q;
   assign frag_next  = frag_cnt_q + CNT_WIDTH'(1);
   assign merge_end  = pkt_in_tlast_i && (frag_next >= cnt_target);
   assign s_ge_w     = (s >= BW'(W));
   assign s_gt_w     = (s > BW'(W));
   assign emit       = merge_end || s_ge_w;
   assign out_load   = !out_valid_q || pkt_out_tready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         r_q         <= '0;
         res_data_q  <= '0;
         res_keep_q  <= '0;
         res_strb_q  <= '0;
         frag_cnt_q  <= '0;
         merge_cnt_q <= '0;
         id_q        <= '0;
         dest_q      <= '0;
         user_q      <= '0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_strb_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_id_q    <= '0;
         out_dest_q  <= '0;
         out_user_q  <= '0;
      end else if (out_load) begin
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         case (state_q)
            ST_FLUSH: begin
               // Residue holds the s-W overflow bytes of the closing beat.
               out_valid_q <= 1'b1;
               out_last_q  <= 1'b1;
               out_data_q  <= res_data_q;
               out_keep_q  <= res_keep_q;
               out_strb_q  <= res_strb_q;
               out_id_q    <= id_q;
               out_dest_q  <= dest_q;
               out_user_q  <= user_q;
               res_data_q  <= '0;
               res_keep_q  <= '0;
               res_strb_q  <= '0;
               r_q         <= '0;
               state_q     <= ST_IDLE;
            end
            default: begin
               if (pkt_in_tvalid_i) begin
                  if (first_beat) begin
                     merge_cnt_q <= cnt_live;
                     id_q        <= pkt_in_tid_i;
                     dest_q      <= pkt_in_tdest_i;
                     user_q      <= pkt_in_tuser_i;
                  end
                  if (emit) begin
                     out_valid_q <= 1'b1;
                     out_data_q  <= packed_data[DATA_WIDTH-1:0];
                     out_keep_q  <= packed_keep[W-1:0];
                     out_strb_q  <= packed_strb[W-1:0];
                     out_id_q    <= first_beat ? pkt_in_tid_i : id_q;
                     out_dest_q  <= first_beat ? pkt_in_tdest_i : dest_q;
                     out_user_q  <= first_beat ? pkt_in_tuser_i : user_q;
                  end
                  state_q <= ST_MERGE;
                  if (merge_end) begin
                     frag_cnt_q <= '0;
                     if (s_gt_w) begin
                        res_data_q <= packed_data[2*DATA_WIDTH-1:DATA_WIDTH];
                        res_keep_q <= packed_keep[2*W-1:W];
                        res_strb_q <= packed_strb[2*W-1:W];
                        r_q        <= s - BW'(W);
                        state_q    <= ST_FLUSH;
                     end else begin
                        // Also covers s == 0: a zero-keep beat still closes the packet.
                        out_last_q <= 1'b1;
                        res_data_q <= '0;
                        res_keep_q <= '0;
                        res_strb_q <= '0;
                        r_q        <= '0;
                        state_q    <= ST_IDLE;
                     end
                  end else begin
                     if (pkt_in_tlast_i) begin
                        frag_cnt_q <= frag_next;
                     end
                     if (s_ge_w) begin
                        res_data_q <= packed_data[2*DATA_WIDTH-1:DATA_WIDTH];
                        res_keep_q <= packed_keep[2*W-1:W];
                        res_strb_q <= packed_strb[2*W-1:W];
                        r_q        <= s - BW'(W);
                     end else begin
                        res_data_q <= packed_data[DATA_WIDTH-1:0];
                        res_keep_q <= packed_keep[W-1:0];
                        res_strb_q <= packed_strb[W-1:0];
                        r_q        <= s;
                     end
                  end
               end
            end
         endcase
      end
   end

   // The flush beat is produced from the residue alone, so input is stalled for it.
   assign pkt_in_tready_o  = out_load && (state_q != ST_FLUSH);
   assign pkt_out_tdata_o  = out_data_q;
   assign pkt_out_tkeep_o  = out_keep_q;
   assign pkt_out_tstrb_o  = out_strb_q;
   assign pkt_out_tlast_o  = out_last_q;
   assign pkt_out_tvalid_o = out_valid_q;
   assign pkt_out_tid_o    = out_id_q;
   assign pkt_out_tdest_o  = out_dest_q;
   assign pkt_out_tuser_o  = out_user_q;

endmodule

// File: tb/tb_axi4_stream_pkt_merge.sv
// tb/tb_axi4_stream_pkt_merge.sv - self-checking bench for axi4_stream_pkt_merge
module tb_axi4_stream_pkt_merge;

   localparam int DW   = 32;
   localparam int W    = 4;
   localparam int IDW  = 4;
   localparam int DSW  = 4;
   localparam int USW  = 4;
   localparam int MAXC = 16;
   localparam int CW   = $clog2(MAXC) + 1;

   logic           clk = 1'b0;
   logic           rst;
   logic [CW-1:0]  merge_cnt;
   logic [DW-1:0]  in_tdata;
   logic [W-1:0]   in_tkeep, in_tstrb;
   logic           in_tlast, in_tvalid, in_tready;
   logic [IDW-1:0] in_tid;
   logic [DSW-1:0] in_tdest;
   logic [USW-1:0] in_tuser;
   logic [DW-1:0]  out_tdata;
   logic [W-1:0]   out_tkeep, out_tstrb;
   logic           out_tlast, out_tvalid;
   logic           out_tready = 1'b1;
   logic [IDW-1:0] out_tid;
   logic [DSW-1:0] out_tdest;
   logic [USW-1:0] out_tuser;
   logic           bp_en = 1'b0;

   always #5 clk = ~clk;

   axi4_stream_pkt_merge #(
      .DATA_WIDTH(DW), .ID_WIDTH(IDW), .DEST_WIDTH(DSW), .USER_WIDTH(USW),
      .MAX_MERGE_CNT(MAXC), .CNT_WIDTH(CW)
   ) dut (
      .clk_i(clk), .rst_i(rst), .merge_cnt_i(merge_cnt),
      .pkt_in_tdata_i(in_tdata), .pkt_in_tkeep_i(in_tkeep), .pkt_in_tstrb_i(in_tstrb),
      .pkt_in_tlast_i(in_tlast), .pkt_in_tid_i(in_tid), .pkt_in_tdest_i(in_tdest),
      .pkt_in_tuser_i(in_tuser), .pkt_in_tvalid_i(in_tvalid), .pkt_in_tready_o(in_tready),
      .pkt_out_tdata_o(out_tdata), .pkt_out_tkeep_o(out_tkeep), .pkt_out_tstrb_o(out_tstrb),
      .pkt_out_tlast_o(out_tlast), .pkt_out_tid_o(out_tid), .pkt_out_tdest_o(out_tdest),
      .pkt_out_tuser_o(out_tuser), .pkt_out_tvalid_o(out_tvalid), .pkt_out_tready_i(out_tready)
   );

   int checks = 0;
   int errors = 0;

   logic [DW-1:0]  cap_data[$];
   logic [W-1:0]   cap_keep[$];
   logic           cap_last[$];
   logic [IDW-1:0] cap_id[$];
   logic [DSW-1:0] cap_dest[$];
   logic [USW-1:0] cap_user[$];
   int             low_cycles = 0;
   int             rd = 0;
   logic [7:0]     exp_bytes[$];

   always @(negedge clk) begin
      if (!rst) begin
         if (out_tvalid && out_tready) begin
            cap_data.push_back(out_tdata);
            cap_keep.push_back(out_tkeep);
            cap_last.push_back(out_tlast);
            cap_id.push_back(out_tid);
            cap_dest.push_back(out_tdest);
            cap_user.push_back(out_tuser);
         end
         if (!in_tready) low_cycles++;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_tready = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] keep_of(input int nb);
      logic [W-1:0] k;
      k = '0;
      for (int i = 0; i < W; i++) if (i < nb) k[i] = 1'b1;
      return k;
   endfunction

   function automatic logic [DW-1:0] byte_mask(input logic [W-1:0] k);
      logic [DW-1:0] m;
      m = '0;
      for (int i = 0; i < W; i++) if (k[i]) m[8*i +: 8] = 8'hFF;
      return m;
   endfunction

   task automatic send_beat(input logic [DW-1:0] data, input int nb, input logic last,
                            input logic [IDW-1:0] id, input logic [DSW-1:0] dest,
                            input logic [USW-1:0] user);
      logic acc;
      int   guard;
      in_tdata  = data;
      in_tkeep  = keep_of(nb);
      in_tstrb  = keep_of(nb);
      in_tlast  = last;
      in_tid    = id;
      in_tdest  = dest;
      in_tuser  = user;
      in_tvalid = 1'b1;
      acc   = 1'b0;
      guard = 0;
      while (!acc && guard < 2000) begin
         @(negedge clk);
         acc = in_tready;
         @(posedge clk);
         #1;
         guard++;
      end
      in_tvalid = 1'b0;
      chk("in_accept", 64'(acc), 64'(1));
   endtask

   // Sends one fragment of len random bytes; garbage above the valid bytes must be ignored.
   task automatic send_frag(input int len, input logic [IDW-1:0] id,
                            input logic [DSW-1:0] dest, input logic [USW-1:0] user);
      int            off;
      int            n;
      logic [7:0]    b;
      logic [DW-1:0] data;
      off = 0;
      while (off < len) begin
         n    = (len - off < W) ? (len - off) : W;
         data = DW'($urandom);
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            data[8*i +: 8] = b;
            exp_bytes.push_back(b);
         end
         send_beat(data, n, (off + n >= len), id, dest, user);
         off += n;
      end
   endtask

   task automatic check_beat(input string tag, input logic [DW-1:0] ed, input logic [W-1:0] ek,
                             input logic el, input logic [IDW-1:0] eid,
                             input logic [DSW-1:0] edest, input logic [USW-1:0] euser);
      int guard;
      guard = 0;
      while (cap_keep.size() <= rd && guard < 5000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      chk({tag, "_present"}, 64'(cap_keep.size() > rd), 64'(1));
      if (cap_keep.size() > rd) begin
         chk({tag, "_data"}, 64'(cap_data[rd] & byte_mask(ek)), 64'(ed));
         chk({tag, "_keep"}, 64'(cap_keep[rd]), 64'(ek));
         chk({tag, "_last"}, 64'(cap_last[rd]), 64'(el));
         chk({tag, "_id"},   64'(cap_id[rd]),   64'(eid));
         chk({tag, "_dest"}, 64'(cap_dest[rd]), 64'(edest));
         chk({tag, "_user"}, 64'(cap_user[rd]), 64'(euser));
         rd++;
      end
   endtask

   // Reference: the merged packet is the concatenation of all fragment bytes,
   // cut into W-byte beats; only the final beat may be short and carries tlast.
   task automatic expect_group(input string tag, input logic [IDW-1:0] id,
                               input logic [DSW-1:0] dest, input logic [USW-1:0] user);
      int            total;
      int            nb;
      int            n;
      logic [DW-1:0] ed;
      total = exp_bytes.size();
      nb    = (total + W - 1) / W;
      for (int b = 0; b < nb; b++) begin
         n  = (total - b * W < W) ? (total - b * W) : W;
         ed = '0;
         for (int i = 0; i < n; i++) ed[8*i +: 8] = exp_bytes[b*W + i];
         check_beat($sformatf("%s_b%0d", tag, b), ed, keep_of(n), (b == nb - 1), id, dest, user);
      end
      exp_bytes.delete();
   endtask

   int base;

   initial begin
      rst = 1'b1; merge_cnt = CW'(1);
      in_tdata = '0; in_tkeep = '0; in_tstrb = '0; in_tlast = 1'b0; in_tvalid = 1'b0;
      in_tid = '0; in_tdest = '0; in_tuser = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", 64'(out_tvalid), 64'(0));
      chk("rst_tlast",  64'(out_tlast),  64'(0));
      chk("rst_tdata",  64'(out_tdata),  64'(0));
      chk("rst_tkeep",  64'(out_tkeep),  64'(0));
      chk("rst_tid",    64'(out_tid),    64'(0));
      chk("rst_tready", 64'(in_tready),  64'(1));
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 7B single fragment -> F,7
      merge_cnt = CW'(1);
      send_frag(7, 4'h1, 4'h2, 4'h3);
      expect_group("t1", 4'h1, 4'h2, 4'h3);

      // 6B+6B -> F,F,F; side-band from the first fragment
      merge_cnt = CW'(2);
      send_frag(6, 4'h4, 4'h5, 4'h6);
      send_frag(6, 4'h7, 4'h8, 4'h9);
      expect_group("t2", 4'h4, 4'h5, 4'h6);

      // 5B x3 -> F,F,F,7
      merge_cnt = CW'(3);
      send_frag(5, 4'hA, 4'hB, 4'hC);
      send_frag(5, 4'h1, 4'h1, 4'h1);
      send_frag(5, 4'h2, 4'h2, 4'h2);
      expect_group("t3", 4'hA, 4'hB, 4'hC);

      // 3B+6B -> F,F,1 with exactly one input bubble for the flush beat
      base = low_cycles;
      merge_cnt = CW'(2);
      send_frag(3, 4'h3, 4'h4, 4'h5);
      send_frag(6, 4'h6, 4'h7, 4'h8);
      expect_group("t4", 4'h3, 4'h4, 4'h5);
      repeat (3) @(posedge clk);
      #1;
      chk("t4_ready_low_cycles", 64'(low_cycles - base), 64'(1));

      // merge_cnt of zero behaves as one
      merge_cnt = CW'(0);
      send_frag(5, 4'hE, 4'hD, 4'hC);
      expect_group("t_cnt0", 4'hE, 4'hD, 4'hC);

      // Closing beat with no bytes and an empty residue still ends the packet
      merge_cnt = CW'(1);
      send_beat(32'h44332211, 4, 1'b0, 4'h9, 4'h8, 4'h7);
      send_beat(32'hDEADBEEF, 0, 1'b1, 4'h1, 4'h1, 4'h1);
      check_beat("t_empty_b0", 32'h44332211, 4'hF, 1'b0, 4'h9, 4'h8, 4'h7);
      check_beat("t_empty_b1", 32'h0, 4'h0, 1'b1, 4'h9, 4'h8, 4'h7);

      // Random fragments with output back-pressure; mid-packet merge_cnt changes ignored
      bp_en = 1'b1;
      for (int g = 0; g < 6; g++) begin
         logic [IDW-1:0] id0;
         logic [DSW-1:0] dest0;
         logic [USW-1:0] user0;
         id0   = IDW'($urandom);
         dest0 = DSW'($urandom);
         user0 = USW'($urandom);
         merge_cnt = CW'(4);
         send_frag($urandom_range(1, 40), id0, dest0, user0);
         merge_cnt = CW'($urandom_range(1, 3));
         for (int f = 1; f < 4; f++) begin
            send_frag($urandom_range(1, 40), IDW'($urandom), DSW'($urandom), USW'($urandom));
         end
         expect_group($sformatf("t5_g%0d", g), id0, dest0, user0);
      end
      bp_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset in the middle of a merge with two residue bytes held
      merge_cnt = CW'(2);
      send_beat(32'hA4A3A2A1, 4, 1'b0, 4'h5, 4'h6, 4'h7);
      send_beat(32'h0000B2B1, 2, 1'b1, 4'h5, 4'h6, 4'h7);
      check_beat("t6_pre", 32'hA4A3A2A1, 4'hF, 1'b0, 4'h5, 4'h6, 4'h7);
      rst = 1'b1;
      #2;
      chk("t6_rst_tvalid", 64'(out_tvalid), 64'(0));
      chk("t6_rst_tlast",  64'(out_tlast),  64'(0));
      chk("t6_rst_tdata",  64'(out_tdata),  64'(0));
      chk("t6_rst_tkeep",  64'(out_tkeep),  64'(0));
      chk("t6_rst_tstrb",  64'(out_tstrb),  64'(0));
      chk("t6_rst_tid",    64'(out_tid),    64'(0));
      chk("t6_rst_tdest",  64'(out_tdest),  64'(0));
      chk("t6_rst_tuser",  64'(out_tuser),  64'(0));
      chk("t6_rst_tready", 64'(in_tready),  64'(1));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      merge_cnt = CW'(1);
      send_frag(4, 4'h2, 4'h3, 4'h4);
      expect_group("t6_post", 4'h2, 4'h3, 4'h4);

      repeat (5) @(posedge clk);
      #1;
      chk("no_extra_beats", 64'(cap_keep.size() - rd), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
